// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit sequencer.
//   state_e          : sequencer state codes (also driven on the debug state port)
//   OP_*             : instruction opcodes as decoded from DR[7:6]
//   DEFAULT_TIMEOUT  : default memory-read wait budget in cycles
//   is_mem_state()   : true for the states that issue a memory read
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,
        S_FETCH2 = 4'd1,
        S_FETCH3 = 4'd2,
        S_ADD1   = 4'd3,
        S_ADD2   = 4'd4,
        S_AND1   = 4'd5,
        S_AND2   = 4'd6,
        S_JMP1   = 4'd7,
        S_INC1   = 4'd8,
        S_HALT   = 4'd9,
        S_FAULT  = 4'd10
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH2) || (s == S_ADD1) || (s == S_AND1);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory-read wait counter.
//   clk     : system clock
//   clr_n   : synchronous active-low reset
//   clear   : zero the count (asserted whenever the sequencer is not waiting)
//   enable  : count one wait cycle
//   expired : the current wait cycle is the last one allowed (count == TIMEOUT-1)
module cu_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!clr_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flagged one cycle early so the FAULT transition happens on the
    // TIMEOUT-th consecutive wait cycle rather than one cycle later.
    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cu_sequencer.sv
// Control sequencer for the simple CPU: FETCH/execute state machine with a
// memory-read handshake and timeout, run/halt/single-step control and a
// retired-instruction counter.
//   clk, clr_n          : clock, synchronous active-low reset
//   run, step           : continuous-run level, single-instruction pulse
//   opcode              : DR[7:6], decoded in FETCH3
//   mem_ready / mem_req : memory read handshake
//   ar_*, pc_*, dr_load, ir_load, ac_* : one-cycle register-transfer enables
//   state, halted, fault, retired      : status and debug
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_BITS = 2,
    parameter int unsigned STATE_BITS  = 4,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   run,
    input  logic                   step,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   ar_load_pc,
    output logic                   ar_load_dr,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   dr_load,
    output logic                   ir_load,
    output logic                   ac_add,
    output logic                   ac_and,
    output logic                   ac_inc,
    output logic [STATE_BITS-1:0]  state,
    output logic                   halted,
    output logic                   fault,
    output logic [RETIRE_W-1:0]    retired
);

    state_e              state_q, state_d;
    logic                step_q, step_d;
    logic                retire;
    logic                end_instr;
    logic                waiting;
    logic                expired;
    logic [RETIRE_W-1:0] retired_q;

    // Memory states are never back-to-back, so clearing whenever not waiting
    // guarantees a zero count on entry to every memory state.
    assign waiting = is_mem_state(state_q) && !mem_ready;

    cu_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .clr_n   (clr_n),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= S_HALT;
            step_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        end_instr  = 1'b0;
        mem_req    = 1'b0;
        ar_load_pc = 1'b0;
        ar_load_dr = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        dr_load    = 1'b0;
        ir_load    = 1'b0;
        ac_add     = 1'b0;
        ac_and     = 1'b0;
        ac_inc     = 1'b0;

        case (state_q)
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH1;
                end else if (step) begin
                    state_d = S_FETCH1;
                    step_d  = 1'b1;
                end
            end
            S_FETCH1: begin
                ar_load_pc = 1'b1;
                state_d    = S_FETCH2;
            end
            S_FETCH2: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    dr_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_FETCH3;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_FETCH3: begin
                ir_load    = 1'b1;
                ar_load_dr = 1'b1;
                case (opcode)
                    OP_ADD:  state_d = S_ADD1;
                    OP_AND:  state_d = S_AND1;
                    OP_JMP:  state_d = S_JMP1;
                    default: state_d = S_INC1;
                endcase
            end
            S_ADD1, S_AND1: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    dr_load = 1'b1;
                    state_d = (state_q == S_ADD1) ? S_ADD2 : S_AND2;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_ADD2: begin
                ac_add    = 1'b1;
                end_instr = 1'b1;
            end
            S_AND2: begin
                ac_and    = 1'b1;
                end_instr = 1'b1;
            end
            S_JMP1: begin
                pc_load   = 1'b1;
                end_instr = 1'b1;
            end
            S_INC1: begin
                ac_inc    = 1'b1;
                end_instr = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (end_instr) begin
            if (run && !step_q) begin
                state_d = S_FETCH1;
            end else begin
                state_d = S_HALT;
                step_d  = 1'b0;
            end
        end

        retire = end_instr;

        // Enables are combinational from state, so they are forced low in the
        // reset cycle to abandon the in-flight instruction without side effects.
        if (!clr_n) begin
            retire     = 1'b0;
            mem_req    = 1'b0;
            ar_load_pc = 1'b0;
            ar_load_dr = 1'b0;
            pc_inc     = 1'b0;
            pc_load    = 1'b0;
            dr_load    = 1'b0;
            ir_load    = 1'b0;
            ac_add     = 1'b0;
            ac_and     = 1'b0;
            ac_inc     = 1'b0;
        end
    end

    assign state   = STATE_BITS'(state_q);
    assign halted  = (state_q == S_HALT);
    assign fault   = (state_q == S_FAULT);
    assign retired = retired_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: every cycle the stimulus pushes the
// expected state, enables and retired count; the checker pops and compares
// at the falling edge.
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  opcode = 2'b00;
    logic        mem_ready = 1'b0;
    logic        mem_req, ar_load_pc, ar_load_dr, pc_inc, pc_load;
    logic        dr_load, ir_load, ac_add, ac_and, ac_inc;
    logic [3:0]  state;
    logic        halted, fault;
    logic [15:0] retired;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] F1 = 4'd0, F2 = 4'd1, F3 = 4'd2, A1 = 4'd3, A2 = 4'd4;
    localparam logic [3:0] N1 = 4'd5, N2 = 4'd6, J1 = 4'd7, I1 = 4'd8, H = 4'd9, FLT = 4'd10;

    localparam logic [9:0] E_NONE = 10'h000;
    localparam logic [9:0] E_MREQ = 10'h200, E_ARPC = 10'h100, E_ARDR = 10'h080;
    localparam logic [9:0] E_PCIN = 10'h040, E_PCLD = 10'h020, E_DRLD = 10'h010;
    localparam logic [9:0] E_IRLD = 10'h008, E_ADD = 10'h004, E_AND = 10'h002, E_INC = 10'h001;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [9:0]  en;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];

    cu_sequencer #(
        .OPCODE_BITS (2),
        .STATE_BITS  (4),
        .TIMEOUT     (15),
        .RETIRE_W    (16)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .run        (run),
        .step       (step),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .ar_load_pc (ar_load_pc),
        .ar_load_dr (ar_load_dr),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .dr_load    (dr_load),
        .ir_load    (ir_load),
        .ac_add     (ac_add),
        .ac_and     (ac_and),
        .ac_inc     (ac_inc),
        .state      (state),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Checker: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [9:0] en;
            e  = sb.pop_front();
            en = {mem_req, ar_load_pc, ar_load_dr, pc_inc, pc_load,
                  dr_load, ir_load, ac_add, ac_and, ac_inc};
            checks++;
            assert (state === e.st) else begin
                failures++;
                $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
            end
            checks++;
            assert (en === e.en) else begin
                failures++;
                $error("FAIL %s enables: got %b expected %b", e.tag, en, e.en);
            end
            checks++;
            assert (halted === (e.st == H)) else begin
                failures++;
                $error("FAIL %s halted: got %b expected %b", e.tag, halted, (e.st == H));
            end
            checks++;
            assert (fault === (e.st == FLT)) else begin
                failures++;
                $error("FAIL %s fault: got %b expected %b", e.tag, fault, (e.st == FLT));
            end
            checks++;
            assert (retired === e.ret) else begin
                failures++;
                $error("FAIL %s retired: got %0d expected %0d", e.tag, retired, e.ret);
            end
        end
    end

    // One clock cycle: drive inputs just after the rising edge and record what
    // the outputs must show during this cycle.
    task automatic cyc(input string tag, input logic c, input logic r, input logic s,
                       input logic [1:0] op, input logic rdy,
                       input logic [3:0] est, input logic [9:0] een, input logic [15:0] eret);
        exp_t e;
        @(posedge clk);
        #2;
        clr_n     = c;
        run       = r;
        step      = s;
        opcode    = op;
        mem_ready = rdy;
        e.tag = tag;
        e.st  = est;
        e.en  = een;
        e.ret = eret;
        sb.push_back(e);
    endtask

    initial begin
        // Reset
        cyc("reset", 0, 0, 0, 2'd0, 0, H, E_NONE, 16'd0);

        // INC with zero-wait memory, then a JMP during which run drops
        cyc("inc_halt", 1, 1, 0, 2'd3, 1, H,  E_NONE, 16'd0);
        cyc("inc_f1",   1, 1, 0, 2'd3, 1, F1, E_ARPC, 16'd0);
        cyc("inc_f2",   1, 1, 0, 2'd3, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd0);
        cyc("inc_f3",   1, 1, 0, 2'd3, 1, F3, E_IRLD | E_ARDR, 16'd0);
        cyc("inc_x",    1, 1, 0, 2'd3, 1, I1, E_INC, 16'd0);
        cyc("jmp_f1",   1, 0, 0, 2'd2, 1, F1, E_ARPC, 16'd1);
        cyc("jmp_f2",   1, 0, 0, 2'd2, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd1);
        cyc("jmp_f3",   1, 0, 0, 2'd2, 1, F3, E_IRLD | E_ARDR, 16'd1);
        cyc("jmp_x",    1, 0, 0, 2'd2, 1, J1, E_PCLD, 16'd1);

        // ADD with three wait cycles in ADD1
        cyc("add_halt", 1, 1, 0, 2'd0, 1, H,  E_NONE, 16'd2);
        cyc("add_f1",   1, 1, 0, 2'd0, 1, F1, E_ARPC, 16'd2);
        cyc("add_f2",   1, 1, 0, 2'd0, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd2);
        cyc("add_f3",   1, 1, 0, 2'd0, 0, F3, E_IRLD | E_ARDR, 16'd2);
        for (int i = 0; i < 3; i++)
            cyc("add_wait", 1, 1, 0, 2'd0, 0, A1, E_MREQ, 16'd2);
        cyc("add_rd",   1, 0, 0, 2'd0, 1, A1, E_MREQ | E_DRLD, 16'd2);
        cyc("add_x",    1, 0, 0, 2'd0, 1, A2, E_ADD, 16'd2);

        // Single step JMP; step while busy and run in the last state are ignored
        cyc("stp_halt", 1, 0, 1, 2'd2, 1, H,  E_NONE, 16'd3);
        cyc("stp_f1",   1, 0, 0, 2'd2, 1, F1, E_ARPC, 16'd3);
        cyc("stp_f2",   1, 0, 1, 2'd2, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd3);
        cyc("stp_f3",   1, 0, 0, 2'd2, 1, F3, E_IRLD | E_ARDR, 16'd3);
        cyc("stp_x",    1, 1, 0, 2'd2, 1, J1, E_PCLD, 16'd3);
        cyc("stp_done", 1, 0, 0, 2'd2, 1, H,  E_NONE, 16'd4);

        // Memory timeout in FETCH2, sticky FAULT, recovery by reset
        cyc("flt_halt", 1, 1, 0, 2'd3, 0, H,  E_NONE, 16'd4);
        cyc("flt_f1",   1, 1, 0, 2'd3, 0, F1, E_ARPC, 16'd4);
        for (int i = 0; i < 15; i++)
            cyc("flt_wait", 1, 1, 0, 2'd3, 0, F2, E_MREQ, 16'd4);
        cyc("flt_st1",  1, 0, 1, 2'd3, 1, FLT, E_NONE, 16'd4);
        cyc("flt_st2",  1, 1, 0, 2'd3, 1, FLT, E_NONE, 16'd4);
        cyc("flt_st3",  1, 0, 1, 2'd0, 0, FLT, E_NONE, 16'd4);
        cyc("flt_clr",  0, 0, 0, 2'd0, 0, FLT, E_NONE, 16'd4);

        // AND with a read accepted on the last allowed wait cycle; run drops in AND1
        cyc("and_halt", 1, 1, 0, 2'd1, 0, H,  E_NONE, 16'd0);
        cyc("and_f1",   1, 1, 0, 2'd1, 0, F1, E_ARPC, 16'd0);
        for (int i = 0; i < 14; i++)
            cyc("and_fwait", 1, 1, 0, 2'd1, 0, F2, E_MREQ, 16'd0);
        cyc("and_f2",   1, 1, 0, 2'd1, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd0);
        cyc("and_f3",   1, 1, 0, 2'd1, 0, F3, E_IRLD | E_ARDR, 16'd0);
        cyc("and_wait", 1, 0, 0, 2'd1, 0, N1, E_MREQ, 16'd0);
        cyc("and_rd",   1, 0, 0, 2'd1, 1, N1, E_MREQ | E_DRLD, 16'd0);
        cyc("and_x",    1, 0, 0, 2'd1, 1, N2, E_AND, 16'd0);

        // Reset asserted in ADD2 abandons the instruction
        cyc("rst_halt", 1, 1, 0, 2'd0, 1, H,  E_NONE, 16'd1);
        cyc("rst_f1",   1, 1, 0, 2'd0, 1, F1, E_ARPC, 16'd1);
        cyc("rst_f2",   1, 1, 0, 2'd0, 1, F2, E_MREQ | E_DRLD | E_PCIN, 16'd1);
        cyc("rst_f3",   1, 1, 0, 2'd0, 1, F3, E_IRLD | E_ARDR, 16'd1);
        cyc("rst_a1",   1, 1, 0, 2'd0, 1, A1, E_MREQ | E_DRLD, 16'd1);
        cyc("rst_a2",   0, 1, 0, 2'd0, 1, A2, E_NONE, 16'd1);
        cyc("rst_done", 1, 0, 0, 2'd0, 1, H,  E_NONE, 16'd0);

        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain: pending %0d expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
